// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared definitions for the ADC capture sequencer.
//   state_t      - FSM state encoding (IDLE=0 .. END=5)
//   TAG_*        - two-bit word tags placed in bits [31:30] of every output word
//   RSN_*        - end-of-series reason codes carried in end words
//   series_limit - maximum data words per series for a given limiter value
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_HDR_HI = 3'd3,
    ST_STREAM = 3'd4,
    ST_END    = 3'd5
  } state_t;

  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b10;
  localparam logic [1:0] TAG_END  = 2'b11;

  localparam logic [1:0] RSN_DETRIG = 2'b00;
  localparam logic [1:0] RSN_LIMIT  = 2'b01;
  localparam logic [1:0] RSN_ABORT  = 2'b10;

  // 2^limiter words per series; limiter >= 32 saturates to all ones.
  function automatic logic [31:0] series_limit(input logic [7:0] limiter);
    if (limiter >= 8'd32) begin
      return '1;
    end
    return 32'd1 << limiter[4:0];
  endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// adc_seq_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - write request and word
//   pop          - read request (ignored when empty)
//   dout         - head word, forced to zero while empty
//   full, empty  - occupancy flags
// A push on a full FIFO succeeds when a pop happens in the same cycle.
module adc_seq_fifo
  import adc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: arms on command, triggers on a rising crossing of the
// ADC abs-sum, and frames each capture series as header (2 words), data words
// and an end word (tlast) into an output FIFO feeding an AXI-Stream master.
//   aclk, aresetn          - clock, asynchronous active-low reset
//   arm, abort             - software command pulses
//   trigger_level          - trigger threshold (unsigned)
//   limiter                - log2 of the per-series word limit
//   series_max             - series before auto-disarm, 0 = unlimited
//   cur_adc, cur_sample    - ADC abs-sum and sample timestamp
//   s_axis_*               - ADC sample words (no backpressure)
//   m_axis_*               - framed output stream
//   state, series_count, words_in_series, overflow, dropped_count,
//   first_trigged, last_detrigged - status
// Optional: define ADC_SEQ_HYST_EN to add the 16-bit `hysteresis` input, which
// lowers the detrigger / re-arm threshold to trigger_level - hysteresis
// (saturating at zero).
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        arm,
  input  logic        abort,
  input  logic [15:0] trigger_level,
  input  logic [7:0]  limiter,
  input  logic [15:0] series_max,
`ifdef ADC_SEQ_HYST_EN
  input  logic [15:0] hysteresis,
`endif
  input  logic [15:0] cur_adc,
  input  logic [63:0] cur_sample,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [2:0]  state,
  output logic [15:0] series_count,
  output logic [31:0] words_in_series,
  output logic        overflow,
  output logic [15:0] dropped_count,
  output logic [63:0] first_trigged,
  output logic [63:0] last_detrigged
);

  state_t      cur_st;
  state_t      nxt_st;
  logic        prev_below;
  logic        abort_pend;
  logic        first_seen;
  logic [57:0] ts;
  logic [1:0]  reason;
  logic [1:0]  exit_reason;
  logic [15:0] low_thr;
  logic        below;
  logic        trig;
  logic        abort_now;
  logic [31:0] limit;
  logic [31:0] words_next;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        can_push;
  logic        push_req;
  logic        fifo_push;
  logic        data_acc;
  logic        data_drop;
  logic        series_done;
  logic [32:0] push_word;
  logic [32:0] fifo_dout;
  logic        unused_tdata_msbs;

  assign unused_tdata_msbs = ^s_axis_tdata[31:30];

`ifdef ADC_SEQ_HYST_EN
  assign low_thr = (trigger_level > hysteresis) ? (trigger_level - hysteresis) : '0;
`else
  assign low_thr = trigger_level;
`endif

  assign below       = (cur_adc < low_thr);
  assign trig        = (cur_adc >= trigger_level) && prev_below;
  // A pulse arriving this cycle counts as pending without waiting a cycle.
  assign abort_now   = abort_pend || abort;
  assign limit       = series_limit(limiter);
  assign words_next  = words_in_series + {31'd0, data_acc};
  assign series_done = (series_max != '0) && ((series_count + 16'd1) == series_max);

  assign fifo_pop  = m_axis_tvalid && m_axis_tready;
  assign can_push  = !fifo_full || fifo_pop;
  assign fifo_push = push_req && can_push;

  always_comb begin
    nxt_st      = cur_st;
    push_req    = 1'b0;
    push_word   = '0;
    data_acc    = 1'b0;
    data_drop   = 1'b0;
    exit_reason = RSN_DETRIG;
    case (cur_st)
      ST_IDLE: begin
        if (arm && !abort) begin
          nxt_st = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort_now) begin
          nxt_st = ST_IDLE;
        end else if (trig) begin
          nxt_st = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        push_req  = 1'b1;
        push_word = {1'b0, TAG_HDR, 1'b0, ts[28:0]};
        if (can_push) begin
          nxt_st = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        push_req  = 1'b1;
        push_word = {1'b0, TAG_HDR, 1'b1, ts[57:29]};
        if (can_push) begin
          nxt_st = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (s_axis_tvalid) begin
          push_req  = 1'b1;
          push_word = {1'b0, TAG_DATA, s_axis_tdata[29:0]};
          data_acc  = can_push;
          data_drop = !can_push;
        end
        if (abort_now) begin
          exit_reason = RSN_ABORT;
          nxt_st      = ST_END;
        end else if (words_next == limit) begin
          exit_reason = RSN_LIMIT;
          nxt_st      = ST_END;
        end else if (below) begin
          exit_reason = RSN_DETRIG;
          nxt_st      = ST_END;
        end
      end
      ST_END: begin
        push_req  = 1'b1;
        push_word = {1'b1, TAG_END, reason, words_in_series[27:0]};
        if (can_push) begin
          nxt_st = (abort_now || series_done) ? ST_IDLE : ST_ARMED;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur_st          <= ST_IDLE;
      prev_below      <= 1'b0;
      abort_pend      <= 1'b0;
      first_seen      <= 1'b0;
      ts              <= '0;
      reason          <= RSN_DETRIG;
      series_count    <= '0;
      words_in_series <= '0;
      overflow        <= 1'b0;
      dropped_count   <= '0;
      first_trigged   <= '0;
      last_detrigged  <= '0;
    end else begin
      cur_st     <= nxt_st;
      prev_below <= below;
      abort_pend <= (nxt_st == ST_IDLE) ? 1'b0 : (abort_pend || abort);
      case (cur_st)
        ST_IDLE: begin
          if (nxt_st == ST_ARMED) begin
            series_count  <= '0;
            first_trigged <= '0;
            first_seen    <= 1'b0;
            overflow      <= 1'b0;
            dropped_count <= '0;
          end
        end
        ST_ARMED: begin
          if (nxt_st == ST_HDR_LO) begin
            ts <= cur_sample[57:0];
            if (!first_seen) begin
              first_trigged <= cur_sample;
              first_seen    <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (data_acc) begin
            words_in_series <= words_next;
          end
          if (data_drop) begin
            overflow <= 1'b1;
            if (dropped_count != 16'hFFFF) begin
              dropped_count <= dropped_count + 16'd1;
            end
          end
          if (nxt_st == ST_END) begin
            reason <= exit_reason;
          end
        end
        ST_END: begin
          if (can_push) begin
            series_count    <= series_count + 16'd1;
            last_detrigged  <= cur_sample;
            words_in_series <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  adc_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (fifo_push),
    .din   (push_word),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[31:0];
  assign m_axis_tlast  = fifo_dout[32];
  assign state         = cur_st;

endmodule
